// File: rtl/jtdd_sdram_sched_pkg.sv
// Shared types and constants for the jtdd SDRAM ROM-slot scheduler.
package jtdd_sched_pkg;

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Width of a counter that must be able to hold the value tout.
    function automatic int unsigned cnt_w(input int unsigned tout);
        return (tout < 1) ? 1 : $clog2(tout + 1);
    endfunction

endpackage

// File: rtl/jtdd_sdram_sched_if.sv
// Slot-side ROM buses plus the jtframe SDRAM read port, bundled for the scheduler.
interface jtdd_sdram_sched_if #(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned AW    = 22
) ();

    logic [SLOTS-1:0]                     slot_cs;
    logic [SLOTS*AW-1:0]                  slot_addr;
    logic [SLOTS*jtdd_sched_pkg::DW-1:0]  slot_dout;
    logic [SLOTS-1:0]                     slot_ok;
    logic                                 sdram_req;
    logic [AW-1:0]                        sdram_addr;
    logic                                 sdram_ack;
    logic                                 data_rdy;
    logic [jtdd_sched_pkg::DW-1:0]        data_read;

    modport master (
        input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_dout, slot_ok, sdram_req, sdram_addr
    );

    modport slave (
        output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_dout, slot_ok, sdram_req, sdram_addr
    );

endinterface

// File: rtl/jtdd_sdram_sched_rr.sv
// Round-robin picker: first pending slot at or above rr, wrapping at SLOTS.
module jtdd_sched_rr #(
    parameter  int unsigned SLOTS = 4,
    localparam int unsigned GW    = $clog2(SLOTS)
) (
    input  logic [SLOTS-1:0] pend,
    input  logic [GW-1:0]    rr,
    output logic [GW-1:0]    gnt,
    output logic             any_pend
);

    int unsigned idx;

    always_comb begin
        gnt      = '0;
        any_pend = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            idx = (32'(rr) + k) % SLOTS;
            if (!any_pend && pend[GW'(idx)]) begin
                gnt      = GW'(idx);
                any_pend = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtdd_sdram_sched.sv
// Shares one SDRAM read port between SLOTS ROM requesters, each backed by a
// one-word tagged buffer that is refetched on an address miss.
module jtdd_sdram_sched
    import jtdd_sched_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned AW    = 22,
    parameter int unsigned TOUT  = 63
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              downloading,
    jtdd_sdram_sched_if.master bus
);

    localparam int unsigned GW = $clog2(SLOTS);
    localparam int unsigned CW = cnt_w(TOUT);

    state_t           state, state_d;
    logic [GW-1:0]    gnt_q, gnt_d, rr_q, rr_d, pick;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             req_q, req_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             wr;
    logic             any_pend;
    logic [SLOTS-1:0] valid_q, hit, pend;
    logic [AW-1:0]    saddr  [SLOTS];
    logic [AW-1:0]    tag_q  [SLOTS];
    logic [DW-1:0]    dout_q [SLOTS];

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign saddr[i] = bus.slot_addr[i*AW +: AW];
        assign hit[i]   = valid_q[i] && (tag_q[i] == saddr[i]);
        assign bus.slot_dout[i*DW +: DW] = dout_q[i];
    end

    assign pend           = bus.slot_cs & ~hit;
    assign bus.slot_ok    = bus.slot_cs & hit;
    assign bus.sdram_req  = req_q;
    assign bus.sdram_addr = addr_q;

    jtdd_sched_rr #(.SLOTS(SLOTS)) u_rr (
        .pend     (pend),
        .rr       (rr_q),
        .gnt      (pick),
        .any_pend (any_pend)
    );

    // Next-state and access control
    always_comb begin
        state_d = state;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wr      = 1'b0;
        case (state)
            IDLE: begin
                if (!downloading && any_pend) begin
                    gnt_d   = pick;
                    addr_d  = saddr[pick];
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.sdram_ack) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.data_rdy) begin
                    wr      = 1'b1;
                    rr_d    = (gnt_q == GW'(SLOTS-1)) ? '0 : gnt_q + GW'(1);
                    state_d = IDLE;
                end else if (cnt_q == CW'(TOUT)) begin
                    // abandoned access: rr untouched so the same slot wins again
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            gnt_q  <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
            req_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            state  <= state_d;
            gnt_q  <= gnt_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            addr_q <= addr_d;
        end
    end

    // Slot buffers; a download invalidates everything, including a landing write
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            if (wr) begin
                dout_q[gnt_q] <= bus.data_read;
                tag_q[gnt_q]  <= addr_q;
            end
            if (downloading) begin
                valid_q <= '0;
            end else if (wr) begin
                valid_q[gnt_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtdd_sdram_sched.sv
// Bench for jtdd_sdram_sched: directed scenarios then randomized traffic,
// checked against a per-slot buffer/round-robin model.
module tb_jtdd_sdram_sched;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned AW    = 22;
    localparam int unsigned TOUT  = 63;

    logic clk = 1'b0;
    logic rstn;
    logic downloading;

    always #5 clk = ~clk;

    jtdd_sdram_sched_if #(.SLOTS(SLOTS), .AW(AW)) bus ();

    jtdd_sdram_sched #(.SLOTS(SLOTS), .AW(AW), .TOUT(TOUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .downloading (downloading),
        .bus         (bus)
    );

    logic [AW-1:0] addr_arr [SLOTS];
    for (genvar i = 0; i < SLOTS; i++) begin : g_addr
        assign bus.slot_addr[i*AW +: AW] = addr_arr[i];
    end

    // Reference model of the slot buffers and arbitration pointer
    bit            m_valid [SLOTS];
    logic [AW-1:0] m_tag   [SLOTS];
    logic [31:0]   m_data  [SLOTS];
    int            m_rr;

    int            n_cmp = 0;
    int            n_fail = 0;
    bit            grant_seen, req_prev, pend_before, dl_edge;
    int            exp_s;
    logic [AW-1:0] exp_a;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int model_pick();
        if (!rstn || downloading) return -1;
        for (int k = 0; k < int'(SLOTS); k++) begin
            int i = (m_rr + k) % SLOTS;
            if (bus.slot_cs[i] && !(m_valid[i] && m_tag[i] == addr_arr[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [SLOTS-1:0] model_ok();
        logic [SLOTS-1:0] v;
        for (int i = 0; i < int'(SLOTS); i++)
            v[i] = bus.slot_cs[i] && m_valid[i] && (m_tag[i] == addr_arr[i]);
        return v;
    endfunction

    function automatic logic [SLOTS*32-1:0] model_dout();
        logic [SLOTS*32-1:0] v;
        for (int i = 0; i < int'(SLOTS); i++) v[i*32 +: 32] = m_data[i];
        return v;
    endfunction

    // One clock; remembers which slot the rules say wins if req rises at this edge
    task automatic step();
        int p;
        bit rst_edge;
        logic [AW-1:0] pa;
        p = model_pick();
        pend_before = (p >= 0);
        dl_edge = downloading;
        rst_edge = !rstn;
        pa = '0;
        if (p >= 0) pa = addr_arr[p];
        @(posedge clk);
        #1;
        if (rst_edge) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                m_valid[i] = 1'b0;
                m_tag[i] = '0;
                m_data[i] = '0;
            end
            m_rr = 0;
            grant_seen = 1'b0;
        end else if (dl_edge) begin
            for (int i = 0; i < int'(SLOTS); i++) m_valid[i] = 1'b0;
        end
        if (!rst_edge && bus.sdram_req && !req_prev) begin
            grant_seen = 1'b1;
            exp_s = p;
            exp_a = pa;
        end
        req_prev = bus.sdram_req;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!grant_seen && n < 100) begin
            step();
            n++;
        end
        chk("grant_seen", grant_seen, 1'b1);
    endtask

    task automatic transact(input int ack_dly, input int rdy_dly, input logic [31:0] d,
                            input bit chg, input bit dl_mid);
        int s;
        logic [AW-1:0] a;
        wait_grant();
        if (!grant_seen) return;
        grant_seen = 1'b0;
        s = exp_s;
        a = exp_a;
        chk("gnt_expected", s >= 0, 1'b1);
        chk("req_addr", bus.sdram_addr, a);
        repeat (ack_dly) begin
            step();
            chk("req_hold", bus.sdram_req, 1'b1);
            chk("addr_hold", bus.sdram_addr, a);
        end
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        chk("ack_drop", bus.sdram_req, 1'b0);
        if (chg && s >= 0) addr_arr[s] = a + AW'(1);
        if (dl_mid) downloading = 1'b1;
        repeat (rdy_dly) step();
        bus.data_rdy  = 1'b1;
        bus.data_read = d;
        step();
        bus.data_rdy  = 1'b0;
        if (s >= 0) begin
            m_data[s]  = d;
            m_tag[s]   = a;
            m_valid[s] = !dl_edge;
            m_rr       = (s + 1) % SLOTS;
        end
        downloading = 1'b0;
        chk("ok_after_rdy", bus.slot_ok, model_ok());
        chk("dout_after_rdy", bus.slot_dout, model_dout());
        chk("idle_req", bus.sdram_req, 1'b0);
        step();
        chk("b2b_req", bus.sdram_req, pend_before);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        downloading = 1'b0;
        bus.slot_cs = 4'hF;
        bus.sdram_ack = 1'b0;
        bus.data_rdy = 1'b0;
        bus.data_read = '0;
        grant_seen = 1'b0;
        req_prev = 1'b0;
        for (int i = 0; i < int'(SLOTS); i++) addr_arr[i] = AW'($urandom) | AW'(22'h20_0000);

        // reset
        step();
        step();
        chk("rst_req", bus.sdram_req, 1'b0);
        chk("rst_addr", bus.sdram_addr, '0);
        chk("rst_ok", bus.slot_ok, '0);
        chk("rst_dout", bus.slot_dout, '0);
        rstn = 1'b1;
        step();
        chk("rel_req", bus.sdram_req, 1'b1);
        chk("rel_addr", bus.sdram_addr, addr_arr[0]);

        // all four slots missing: round-robin sweep, then slot 0 re-miss, then all again
        for (int k = 0; k < 4; k++) transact(1, 2, $urandom, 1'b0, 1'b0);
        addr_arr[0] = addr_arr[0] + AW'(4);
        transact(0, 1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < int'(SLOTS); i++) addr_arr[i] = addr_arr[i] ^ AW'(22'h00_0F00);
        for (int k = 0; k < 4; k++) transact(2, 1, $urandom, 1'b0, 1'b0);

        // single miss on slot 2
        bus.slot_cs = 4'b0100;
        addr_arr[2] = 22'h06_0010;
        transact(2, 4, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("single_dout", bus.slot_dout[64 +: 32], 32'hDEADBEEF);
        repeat (4) begin
            step();
            chk("single_no_req", bus.sdram_req, 1'b0);
            chk("single_ok", bus.slot_ok[2], 1'b1);
        end
        bus.sdram_ack = 1'b1;
        bus.data_rdy = 1'b1;
        bus.data_read = 32'h1234_5678;
        step();
        bus.sdram_ack = 1'b0;
        bus.data_rdy = 1'b0;
        chk("stray_dout", bus.slot_dout, model_dout());
        chk("stray_req", bus.sdram_req, 1'b0);

        // slot 1 address moves while its fetch is in flight
        bus.slot_cs = 4'b0010;
        addr_arr[1] = 22'h00_0100;
        transact(1, 3, $urandom, 1'b1, 1'b0);
        chk("chg_ok_low", bus.slot_ok[1], 1'b0);
        transact(0, 2, $urandom, 1'b0, 1'b0);
        chk("chg_ok_high", bus.slot_ok[1], 1'b1);

        // timeout: ack but no data
        bus.slot_cs = 4'b1000;
        addr_arr[3] = 22'h2A_5555;
        wait_grant();
        grant_seen = 1'b0;
        chk("tout_addr0", bus.sdram_addr, addr_arr[3]);
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        for (int k = 0; k < int'(TOUT) + 1; k++) begin
            step();
            chk("tout_wait_req", bus.sdram_req, 1'b0);
        end
        step();
        chk("tout_rereq", grant_seen, 1'b1);
        chk("tout_addr", bus.sdram_addr, addr_arr[3]);
        chk("tout_dout", bus.slot_dout, model_dout());
        chk("tout_ok", bus.slot_ok, '0);
        transact(1, 1, $urandom, 1'b0, 1'b0);

        // download invalidates and blocks grants
        bus.slot_cs = 4'b0001;
        addr_arr[0] = 22'h03_0303;
        transact(0, 0, $urandom, 1'b0, 1'b0);
        chk("pre_dl_ok", bus.slot_ok[0], 1'b1);
        downloading = 1'b1;
        step();
        chk("dl_ok", bus.slot_ok, model_ok());
        repeat (4) begin
            step();
            chk("dl_no_req", bus.sdram_req, 1'b0);
        end
        downloading = 1'b0;
        transact(1, 1, $urandom, 1'b0, 1'b0);
        addr_arr[0] = addr_arr[0] + AW'(1);
        transact(1, 2, $urandom, 1'b0, 1'b1);
        transact(0, 1, $urandom, 1'b0, 1'b0);

        // randomized traffic over a small address pool so hits and misses mix
        for (int it = 0; it < 40; it++) begin
            bus.slot_cs = 4'($urandom_range(1, 15));
            for (int i = 0; i < int'(SLOTS); i++)
                if ($urandom_range(0, 2) == 0) addr_arr[i] = AW'(22'h100 + $urandom_range(0, 5));
            if (grant_seen || model_pick() >= 0)
                transact($urandom_range(0, 3), $urandom_range(0, 5), $urandom,
                         $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            else begin
                step();
                chk("rnd_idle_ok", bus.slot_ok, model_ok());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
